// File: rtl/thor2023_vec_sum_if.sv
//----------------------------------------------------------------------------
// Module : thor2023_vec_sum_if
// Brief  : Request/result bundle for the vector-sum reduction unit.
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

interface thor2023_vec_sum_if #(
  parameter int WID = 512
);
  logic             ld;
  logic [2:0]       sz;
  logic             sgn;
  logic             neg;
  logic [WID/8-1:0] mask;
  logic [WID-1:0]   a;
  logic             busy;
  logic             done;
  logic [127:0]     o;

  modport master (
    output ld, sz, sgn, neg, mask, a,
    input  busy, done, o
  );

  modport slave (
    input  ld, sz, sgn, neg, mask, a,
    output busy, done, o
  );
endinterface

`default_nettype wire

// File: rtl/thor2023_vec_sum.sv
//----------------------------------------------------------------------------
// Module : thor2023_vec_sum
// Brief  : Reduces a WID-bit vector of 8..128-bit lanes to a 128-bit masked sum.
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module thor2023_vec_sum #(
  parameter int WID = 512
) (
  input  wire                clk,
  input  wire                rst,
  thor2023_vec_sum_if.slave  bus
);

  localparam int         c_nchunk = WID / 128;
  localparam int         c_cntw   = (c_nchunk > 1) ? $clog2(c_nchunk) : 1;
  localparam logic [c_cntw-1:0] c_last = c_cntw'(c_nchunk - 1);

  localparam logic [2:0] c_prc8  = 3'd0;
  localparam logic [2:0] c_prc16 = 3'd1;
  localparam logic [2:0] c_prc32 = 3'd2;
  localparam logic [2:0] c_prc64 = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_load;
  logic                w_run;
  logic                w_fin;

  logic [WID-1:0]      r_a;
  logic [WID/8-1:0]    r_mask;
  logic [2:0]          r_sz;
  logic                r_sgn;
  logic                r_neg;
  logic [c_cntw-1:0]   r_cnt;
  logic [127:0]        r_acc;
  logic [127:0]        r_o;
  logic                r_done;
  logic                r_busy;

  logic [127:0]        w_chunk_arr  [c_nchunk];
  logic [15:0]         w_mchunk_arr [c_nchunk];
  logic [127:0]        w_chunk;
  logic [15:0]         w_mchunk;
  logic [127:0]        w_lanesum;

  for (genvar g = 0; g < c_nchunk; g++) begin : g_chunk
    assign w_chunk_arr[g]  = r_a[g*128 +: 128];
    assign w_mchunk_arr[g] = r_mask[g*16 +: 16];
  end

  assign w_chunk  = w_chunk_arr[r_cnt];
  assign w_mchunk = w_mchunk_arr[r_cnt];

  // Each lane is gated by the mask bit of its lowest byte.
  always_comb begin
    w_lanesum = '0;
    case (r_sz)
      c_prc8: begin
        for (int i = 0; i < 16; i++)
          if (w_mchunk[i])
            w_lanesum = w_lanesum + (r_sgn ? {{120{w_chunk[8*i+7]}}, w_chunk[8*i +: 8]}
                                           : {120'd0, w_chunk[8*i +: 8]});
      end
      c_prc16: begin
        for (int i = 0; i < 8; i++)
          if (w_mchunk[2*i])
            w_lanesum = w_lanesum + (r_sgn ? {{112{w_chunk[16*i+15]}}, w_chunk[16*i +: 16]}
                                           : {112'd0, w_chunk[16*i +: 16]});
      end
      c_prc32: begin
        for (int i = 0; i < 4; i++)
          if (w_mchunk[4*i])
            w_lanesum = w_lanesum + (r_sgn ? {{96{w_chunk[32*i+31]}}, w_chunk[32*i +: 32]}
                                           : {96'd0, w_chunk[32*i +: 32]});
      end
      c_prc64: begin
        for (int i = 0; i < 2; i++)
          if (w_mchunk[8*i])
            w_lanesum = w_lanesum + (r_sgn ? {{64{w_chunk[64*i+63]}}, w_chunk[64*i +: 64]}
                                           : {64'd0, w_chunk[64*i +: 64]});
      end
      default: begin
        if (w_mchunk[0])
          w_lanesum = w_chunk;
      end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_run       = 1'b0;
    w_fin       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.ld) begin
          w_load      = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_run = 1'b1;
        if (r_cnt == c_last)
          w_state_nxt = ST_FIN;
      end
      ST_FIN: begin
        w_fin       = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_mask  <= '0;
      r_sz    <= '0;
      r_sgn   <= 1'b0;
      r_neg   <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_o     <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_fin;
      r_busy  <= (w_state_nxt != ST_IDLE);
      if (w_load) begin
        r_a    <= bus.a;
        r_mask <= bus.mask;
        r_sz   <= bus.sz;
        r_sgn  <= bus.sgn;
        r_neg  <= bus.neg;
        r_cnt  <= '0;
        r_acc  <= '0;
      end
      // cnt stops at the last chunk; FIN does not advance it.
      if (w_run) begin
        r_acc <= r_acc + w_lanesum;
        if (r_cnt != c_last)
          r_cnt <= r_cnt + 1'b1;
      end
      if (w_fin)
        r_o <= r_neg ? (128'd0 - r_acc) : r_acc;
    end
  end

  assign bus.o    = r_o;
  assign bus.done = r_done;
  assign bus.busy = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_thor2023_vec_sum.sv
//----------------------------------------------------------------------------
// Module : tb_thor2023_vec_sum
// Brief  : Directed self-checking bench for the vector-sum reduction unit.
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_thor2023_vec_sum;

  localparam int WID = 512;
  localparam logic [2:0] PRC8   = 3'd0;
  localparam logic [2:0] PRC16  = 3'd1;
  localparam logic [2:0] PRC32  = 3'd2;
  localparam logic [2:0] PRC64  = 3'd3;
  localparam logic [2:0] PRC128 = 3'd4;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   lat;
  int   ndone;
  logic [WID-1:0]   vec;
  logic [WID/8-1:0] ones;

  thor2023_vec_sum_if #(.WID(WID)) bus ();

  thor2023_vec_sum #(.WID(WID)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start(input logic [2:0] sz, input logic sgn, input logic neg,
                       input logic [WID/8-1:0] mask, input logic [WID-1:0] a);
    bus.sz   = sz;
    bus.sgn  = sgn;
    bus.neg  = neg;
    bus.mask = mask;
    bus.a    = a;
    bus.ld   = 1'b1;
    @(posedge clk);
    #1;
    bus.ld   = 1'b0;
  endtask

  // Counts edges after the ld edge until done is seen (bounded).
  task automatic wait_done(output int n);
    n = 0;
    while (n < 20 && bus.done !== 1'b1) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    ones  = '1;
    rst   = 1'b1;
    bus.ld = 1'b0; bus.sz = '0; bus.sgn = 1'b0; bus.neg = 1'b0;
    bus.mask = '0; bus.a = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 128'(bus.busy), 128'd0);
    chk("rst_done", 128'(bus.done), 128'd0);
    chk("rst_o", bus.o, 128'd0);
    rst = 1'b0;

    // bytes of 1, unsigned
    start(PRC8, 1'b0, 1'b0, ones, {64{8'h01}});
    chk("busy_run", 128'(bus.busy), 128'd1);
    wait_done(lat);
    chk("lat_p8", 128'(lat), 128'd5);
    chk("o_p8_ones", bus.o, 128'h40);
    chk("busy_fin", 128'(bus.busy), 128'd0);
    @(posedge clk); #1;
    chk("done_pulse", 128'(bus.done), 128'd0);

    start(PRC8, 1'b1, 1'b0, ones, {64{8'hFF}});
    wait_done(lat);
    chk("o_p8_ff_sgn", bus.o, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFC0);

    start(PRC8, 1'b0, 1'b0, ones, {64{8'hFF}});
    wait_done(lat);
    chk("o_p8_ff_uns", bus.o, 128'h3FC0);

    // lane0 only, negated; inputs scrambled after ld must not matter
    for (int i = 0; i < 16; i++) vec[32*i +: 32] = (i == 0) ? 32'd5 : 32'd7;
    start(PRC32, 1'b0, 1'b1, 64'h1, vec);
    bus.a = '1; bus.mask = '1; bus.neg = 1'b0; bus.sz = PRC8;
    wait_done(lat);
    chk("o_p32_neg", bus.o, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFB);

    // halves 0..15 of -32768
    start(PRC16, 1'b1, 1'b0, 64'h0000_0000_FFFF_FFFF, {32{16'h8000}});
    wait_done(lat);
    chk("o_p16_sgn", bus.o, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFF80000);

    // mask bits only on odd bytes: no halfword lane is active
    start(PRC16, 1'b1, 1'b0, 64'hAAAA_AAAA_AAAA_AAAA, {32{16'h8000}});
    wait_done(lat);
    chk("o_p16_oddmask", bus.o, 128'd0);

    start(PRC64, 1'b0, 1'b1, ones, {8{64'h0000_0001_0000_0000}});
    wait_done(lat);
    chk("o_p64_neg", bus.o, 128'hFFFFFFFF_FFFFFFFF_FFFFFFF8_00000000);

    start(PRC8, 1'b1, 1'b1, '0, {64{8'hFF}});
    wait_done(lat);
    chk("o_mask0_neg", bus.o, 128'd0);

    // ld pulses during cycles 2 and 3 are ignored
    start(PRC8, 1'b0, 1'b0, ones, {64{8'h01}});
    bus.a = {64{8'h02}};
    ndone = 0;
    for (int k = 1; k <= 12; k++) begin
      bus.ld = (k == 2 || k == 3);
      @(posedge clk); #1;
      if (bus.done === 1'b1) ndone++;
    end
    bus.ld = 1'b0;
    chk("ld_busy_ndone", 128'(ndone), 128'd1);
    chk("ld_busy_o", bus.o, 128'h40);

    // asynchronous abort mid-operation
    start(PRC8, 1'b0, 1'b0, ones, {64{8'h03}});
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy", 128'(bus.busy), 128'd0);
    chk("abort_done", 128'(bus.done), 128'd0);
    chk("abort_o", bus.o, 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) ndone++;
    end
    chk("abort_nodone", 128'(ndone), 128'd0);
    start(PRC8, 1'b0, 1'b0, ones, {64{8'h03}});
    wait_done(lat);
    chk("post_abort_lat", 128'(lat), 128'd5);
    chk("post_abort_o", bus.o, 128'hC0);

    // back-to-back 128-bit ops, first wraps modulo 2^128
    start(PRC128, 1'b0, 1'b0, ones, '1);
    wait_done(lat);
    chk("b2b1_o", bus.o, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFC);
    start(PRC128, 1'b0, 1'b0, ones, {4{128'd1}});
    wait_done(lat);
    chk("b2b2_lat", 128'(lat), 128'd5);
    chk("b2b2_o", bus.o, 128'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/thor2023_vec_sum.md
THOR2023_VEC_SUM -- requirements
Module: Thor2023_vec_sum

Interface
REQ-001 Parameter WID, default 512, vector width in bits; SHALL be a multiple of 128.
REQ-002 Port rst, input, 1, reset; SHALL be asynchronous and active-high.
REQ-003 Port clk, input, 1, single clock; all state SHALL update on its rising edge.
REQ-004 Port ld, input, 1, start request; SHALL be accepted only when idle.
REQ-005 Port sz, input, 3, element size (Thor2023Pkg encodings): PRC8, PRC16, PRC32 or PRC64; any other value SHALL select 128-bit elements.
REQ-006 Port sgn, input, 1, 1 = elements sign-extended, 0 = zero-extended.
REQ-007 Port neg, input, 1, 1 = final result negated.
REQ-008 Port mask, input, WID/8, lane enable; a lane SHALL be active when the mask bit of its lowest byte is 1.
REQ-009 Port a, input, WID, source vector.
REQ-010 Port busy, output, 1, high while a reduction is in progress.
REQ-011 Port done, output, 1, one-cycle completion pulse.
REQ-012 Port o, output, 128, scalar result.

Function
REQ-013 Block SHALL reduce vector a to one scalar: sum of all active lanes, each extended to 128 bits per sgn, modulo 2^128.
REQ-014 FSM SHALL have exactly three states: IDLE, RUN, FIN.
REQ-015 IDLE, edge with ld=1: SHALL latch a, sz, sgn, neg and mask, clear the accumulator and the chunk counter, set busy=1 and enter RUN.
REQ-016 RUN: each edge SHALL add the sum of active lanes of 128-bit chunk[cnt] of latched a to the accumulator, then increment cnt.
REQ-017 RUN SHALL go to FIN on the edge that processes chunk WID/128-1; cnt SHALL never wrap inside one operation.
REQ-018 FIN, one edge: SHALL register o = neg ? -acc : acc, pulse done=1 for exactly one cycle, clear busy and return to IDLE.
REQ-019 Latency: ld sampled at edge E0 SHALL produce done and a valid o after edge E0+WID/128+1 (5 edges for WID=512).
REQ-020 ld while busy=1 SHALL be ignored, with no effect on the operation in progress.
REQ-021 ld SHALL be accepted on the edge immediately after done (back-to-back operation).
REQ-022 o SHALL hold its value until the next FIN; input changes after the ld edge SHALL NOT affect the result.
REQ-023 mask all zero SHALL give o = 0 (or -0 = 0 when neg=1).
REQ-024 Lane sums SHALL be computed combinationally per chunk; there SHALL be one accumulator add per clock.

Reset
REQ-025 rst=1 SHALL force IDLE, busy=0, done=0, o=0, accumulator=0 and cnt=0 immediately, independent of clk.
REQ-026 rst asserted mid-operation SHALL abort the operation; no done pulse SHALL follow.
REQ-027 After rst deasserts, the first ld SHALL be accepted on the next edge.

Verification
REQ-028 sz=PRC8, sgn=0, mask all ones, all bytes 0x01, neg=0 -> o=64 (0x40), done 5 cycles after ld.
REQ-029 sz=PRC8, all bytes 0xFF, mask all ones: sgn=1 -> o=0xFFFF...FFC0 (-64); sgn=0 -> o=0x3FC0.
REQ-030 sz=PRC32, lane0=5, all other lanes 7, mask enabling lane 0 only, neg=1 -> o=0xFFFF...FFFB (-5).
REQ-031 ld pulsed again at cycles 2 and 3 of an operation -> ignored; exactly one done; o equals the first operation's result.
REQ-032 rst asserted at cycle 3 of an operation -> busy=0, done=0 and o=0 at once; no later done; the next ld completes normally.
REQ-033 Two operations back-to-back (ld on the edge after done), sz=PRC128 with 0xFFFF...FF in all lanes -> first o = 0xFFFF...FC (wrap-around modulo 2^128); second result correct with no leftover accumulator.
